// File: rtl/demux2_one.sv
// ---------------------------------------------------------------------------
// demux2_one
//   Break-before-make 1-to-2 demultiplexer. The serial stream x is steered to
//   y1 (sel=0) or y0 (sel=1). A route change waits for QUIET consecutive zero
//   cycles on x, then forces both outputs low for GUARD cycles, and only then
//   enables the new destination, so the two outputs never carry x together.
//
// Parameters
//   GUARD  cycles both outputs are held 0 during a switch (1..255)
//   QUIET  consecutive x=0 cycles needed before a switch starts (0..255)
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   sel         requested route, asynchronous to clk (0 -> y1, 1 -> y0)
//   x           data stream, synchronous to clk
//   y0          registered output for route sel=1
//   y1          registered output for route sel=0
//   active_sel  route currently in effect
//   switching   high while a route change is pending or in guard
// ---------------------------------------------------------------------------
module demux2_one #(
  parameter int GUARD = 4,
  parameter int QUIET = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sel,
  input  logic x,
  output logic y0,
  output logic y1,
  output logic active_sel,
  output logic switching
);

  typedef enum logic [1:0] {
    S_ROUTE      = 2'd0,
    S_QUIET_WAIT = 2'd1,
    S_GUARD      = 2'd2
  } state_t;

  // Terminal counts. With QUIET=0 the quiet wait is skipped entirely, so its
  // terminal value is never used; it is clamped to keep the width sane.
  localparam logic [7:0] QUIET_LAST = (QUIET > 0) ? 8'(QUIET - 1) : 8'd0;
  localparam logic [7:0] GUARD_LAST = (GUARD > 0) ? 8'(GUARD - 1) : 8'd0;

  state_t     state;
  logic       sel_m;
  logic       sel_s;
  logic       target;
  logic [7:0] quiet_cnt;
  logic [7:0] guard_cnt;

  // Saturating increment so neither counter can ever wrap.
  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // Two-flop synchronizer bringing the asynchronous sel into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_m <= 1'b0;
      sel_s <= 1'b0;
    end else begin
      sel_m <= sel;
      sel_s <= sel_m;
    end
  end

  // Route FSM with registered outputs. Entering GUARD clears both outputs on
  // the same edge, so the first all-zero output cycle is the first guard
  // cycle; the edge that ends the last guard cycle both flips active_sel and
  // loads x into the new destination.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_ROUTE;
      y0         <= 1'b0;
      y1         <= 1'b0;
      active_sel <= 1'b0;
      switching  <= 1'b0;
      target     <= 1'b0;
      quiet_cnt  <= 8'd0;
      guard_cnt  <= 8'd0;
    end else begin
      case (state)
        S_ROUTE: begin
          if (sel_s != active_sel) begin
            switching <= 1'b1;
            if (QUIET == 0) begin
              state     <= S_GUARD;
              target    <= sel_s;
              guard_cnt <= 8'd0;
              y0        <= 1'b0;
              y1        <= 1'b0;
            end else begin
              state     <= S_QUIET_WAIT;
              quiet_cnt <= 8'd0;
              y0        <= x & active_sel;
              y1        <= x & ~active_sel;
            end
          end else begin
            switching <= 1'b0;
            y0        <= x & active_sel;
            y1        <= x & ~active_sel;
          end
        end

        S_QUIET_WAIT: begin
          if (sel_s == active_sel) begin
            state     <= S_ROUTE;
            switching <= 1'b0;
            quiet_cnt <= 8'd0;
            y0        <= x & active_sel;
            y1        <= x & ~active_sel;
          end else if (!x && (quiet_cnt == QUIET_LAST)) begin
            state     <= S_GUARD;
            target    <= sel_s;
            guard_cnt <= 8'd0;
            quiet_cnt <= 8'd0;
            switching <= 1'b1;
            y0        <= 1'b0;
            y1        <= 1'b0;
          end else begin
            switching <= 1'b1;
            quiet_cnt <= x ? 8'd0 : sat_inc(quiet_cnt);
            y0        <= x & active_sel;
            y1        <= x & ~active_sel;
          end
        end

        S_GUARD: begin
          if (guard_cnt == GUARD_LAST) begin
            state      <= S_ROUTE;
            active_sel <= target;
            switching  <= 1'b0;
            guard_cnt  <= 8'd0;
            y0         <= x & target;
            y1         <= x & ~target;
          end else begin
            switching <= 1'b1;
            guard_cnt <= sat_inc(guard_cnt);
            y0        <= 1'b0;
            y1        <= 1'b0;
          end
        end

        default: begin
          state     <= S_ROUTE;
          switching <= 1'b0;
          y0        <= 1'b0;
          y1        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux2_one.sv
// ---------------------------------------------------------------------------
// tb_demux2_one
//   Self-checking bench for demux2_one (GUARD=4, QUIET=2). Inputs change on
//   the falling edge; a behavioural model advances on the rising edge and is
//   compared against the DUT on every falling edge. Directed scenarios add
//   hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_demux2_one;

  localparam int GUARD = 4;
  localparam int QUIET = 2;

  logic clk;
  logic rst;
  logic sel;
  logic x;
  logic y0;
  logic y1;
  logic active_sel;
  logic switching;

  int checks = 0;
  int errors = 0;

  demux2_one #(.GUARD(GUARD), .QUIET(QUIET)) dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .x          (x),
    .y0         (y0),
    .y1         (y1),
    .active_sel (active_sel),
    .switching  (switching)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: sel seen two clocks late, a count of zeros still owed
  // before a switch, and a countdown of guard cycles left.
  logic m_y0, m_y1, m_act, m_sw, m_target, m_waiting;
  logic sh0, sh1;
  int   m_zeros;
  int   m_guard_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_y0 <= 1'b0; m_y1 <= 1'b0; m_act <= 1'b0; m_sw <= 1'b0;
      m_target <= 1'b0; m_waiting <= 1'b0;
      sh0 <= 1'b0; sh1 <= 1'b0;
      m_zeros <= 0; m_guard_left <= 0;
    end else begin
      if (m_guard_left > 0) begin
        if (m_guard_left == 1) begin
          m_act <= m_target;
          m_y0  <= x && m_target;
          m_y1  <= x && !m_target;
          m_sw  <= 1'b0;
        end else begin
          m_y0 <= 1'b0; m_y1 <= 1'b0; m_sw <= 1'b1;
        end
        m_guard_left <= m_guard_left - 1;
      end else if (m_waiting) begin
        if (sh1 == m_act) begin
          m_waiting <= 1'b0;
          m_y0 <= x && m_act; m_y1 <= x && !m_act; m_sw <= 1'b0;
        end else if (!x && (m_zeros + 1 >= QUIET)) begin
          m_waiting <= 1'b0; m_guard_left <= GUARD; m_target <= sh1;
          m_y0 <= 1'b0; m_y1 <= 1'b0; m_sw <= 1'b1;
        end else begin
          m_zeros <= x ? 0 : m_zeros + 1;
          m_y0 <= x && m_act; m_y1 <= x && !m_act; m_sw <= 1'b1;
        end
      end else if (sh1 != m_act) begin
        m_sw <= 1'b1;
        if (QUIET == 0) begin
          m_guard_left <= GUARD; m_target <= sh1;
          m_y0 <= 1'b0; m_y1 <= 1'b0;
        end else begin
          m_waiting <= 1'b1; m_zeros <= 0;
          m_y0 <= x && m_act; m_y1 <= x && !m_act;
        end
      end else begin
        m_y0 <= x && m_act; m_y1 <= x && !m_act; m_sw <= 1'b0;
      end
      sh1 <= sh0;
      sh0 <= sel;
    end
  end

  task automatic checkOutput(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, plus the never-both-driven rule.
  always @(negedge clk) begin
    checkOutput("model_y0", y0, m_y0);
    checkOutput("model_y1", y1, m_y1);
    checkOutput("model_active_sel", active_sel, m_act);
    checkOutput("model_switching", switching, m_sw);
    checkOutput("not_both_high", y0 & y1, 1'b0);
  end

  // One clock of stimulus: inputs set on the falling edge, returns just after
  // the following rising edge.
  task automatic applyStimulus(input logic s, input logic xv, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sel = s;
      x   = xv;
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst = 1'b0;
    sel = 1'b0;
    x   = 1'b1;
    #1 rst = 1'b1;
    #2;
    $display("[TB] reset with x=1");
    checkOutput("reset_y0", y0, 1'b0);
    checkOutput("reset_y1", y1, 1'b0);
    checkOutput("reset_active_sel", active_sel, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("post_reset_y1", y1, 1'b1);
    checkOutput("post_reset_y0", y0, 1'b0);

    $display("[TB] clean switch");
    applyStimulus(1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 2);
    checkOutput("clean_sync_not_yet", switching, 1'b0);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("clean_switching", switching, 1'b1);
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b1, 1'b1, 3);
    checkOutput("clean_guard_y0", y0, 1'b0);
    checkOutput("clean_guard_y1", y1, 1'b0);
    checkOutput("clean_guard_act", active_sel, 1'b0);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("clean_done_act", active_sel, 1'b1);
    checkOutput("clean_done_y0", y0, 1'b1);
    checkOutput("clean_done_sw", switching, 1'b0);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("clean_follow_y0", y0, 1'b0);

    $display("[TB] quiet blocking");
    applyStimulus(1'b0, 1'b1, 8);
    checkOutput("block_switching", switching, 1'b1);
    checkOutput("block_y0", y0, 1'b1);
    applyStimulus(1'b0, 1'b0, 2);
    checkOutput("block_guard_sw", switching, 1'b1);
    applyStimulus(1'b0, 1'b1, 3);
    checkOutput("block_guard_y0", y0, 1'b0);
    checkOutput("block_guard_y1", y1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("block_done_act", active_sel, 1'b0);
    checkOutput("block_done_y1", y1, 1'b1);

    $display("[TB] abort");
    applyStimulus(1'b1, 1'b1, 3);
    checkOutput("abort_pending", switching, 1'b1);
    checkOutput("abort_pending_y1", y1, 1'b1);
    applyStimulus(1'b0, 1'b1, 3);
    checkOutput("abort_sw", switching, 1'b0);
    checkOutput("abort_y1", y1, 1'b1);
    checkOutput("abort_act", active_sel, 1'b0);

    $display("[TB] sel change during guard");
    applyStimulus(1'b1, 1'b0, 5);
    applyStimulus(1'b0, 1'b1, 4);
    checkOutput("gsel_act", active_sel, 1'b1);
    checkOutput("gsel_y0", y0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("gsel_second_sw", switching, 1'b1);
    applyStimulus(1'b0, 1'b0, 5);
    checkOutput("gsel_second_guard_act", active_sel, 1'b1);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("gsel_second_act", active_sel, 1'b0);
    checkOutput("gsel_second_sw_done", switching, 1'b0);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("gsel_second_y1", y1, 1'b1);

    $display("[TB] reset mid-guard");
    applyStimulus(1'b1, 1'b0, 6);
    checkOutput("midguard_sw", switching, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("midguard_rst_sw", switching, 1'b0);
    checkOutput("midguard_rst_act", active_sel, 1'b0);
    checkOutput("midguard_rst_y0", y0, 1'b0);
    checkOutput("midguard_rst_y1", y1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("midguard_resume_y1", y1, 1'b1);
    checkOutput("midguard_resume_sw", switching, 1'b0);
    applyStimulus(1'b0, 1'b0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
